// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    localparam int MIN_DATA_BITS = 5;
    // Wide enough for the largest legal data-bit count (9).
    localparam int CFG_DBW       = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP1    = 3'd4,
        STOP2    = 3'd5,
        BRK_WAIT = 3'd6
    } rx_state_e;

    typedef struct packed {
        logic [CFG_DBW-1:0] data_bits;
        logic               parity_en;
        logic               parity_odd;
        logic               stop2;
    } rx_cfg_t;

    function automatic logic [CFG_DBW-1:0] clamp_data_bits(
        input logic [CFG_DBW-1:0] raw,
        input logic [CFG_DBW-1:0] max_bits
    );
        if (raw < CFG_DBW'(MIN_DATA_BITS)) begin
            return CFG_DBW'(MIN_DATA_BITS);
        end
        if (raw > max_bits) begin
            return max_bits;
        end
        return raw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_shift_parity.sv
// ============================================================================
// Module      : rx_shift_parity
// Description : LSB-first receive shift register with running XOR of shifted bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_shift_parity #(
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_shift_en,
    input  logic                     i_bit,
    output logic [MAX_DATA_BITS-1:0] o_word,
    output logic                     o_xor
);

    logic [MAX_DATA_BITS-1:0] r_word;
    logic                     r_xor;

    // New bits enter at the MSB; a short word ends up MSB-aligned.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_word <= '0;
            r_xor  <= 1'b0;
        end else if (i_shift_en) begin
            r_word <= {i_bit, r_word[MAX_DATA_BITS-1:1]};
            r_xor  <= r_xor ^ i_bit;
        end
    end

    assign o_word = r_word;
    assign o_xor  = r_xor;

endmodule

`default_nettype wire

// File: rtl/rx_frame_sequencer.sv
// ============================================================================
// Module      : rx_frame_sequencer
// Description : UART RX frame sequencer, 5..MAX_DATA_BITS data, optional parity,
//               1/2 stop bits. Optional break detection via RX_BREAK_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_sequencer
    import uart_rx_pkg::*;
#(
    parameter int MAX_DATA_BITS = 8,
    parameter int DBW           = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     start_detect,
    input  logic                     sample_edge,
    input  logic                     rx_bit,
    input  logic [DBW-1:0]           cfg_data_bits,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_odd,
    input  logic                     cfg_stop2,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     receive_done,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     busy,
    output logic                     sample_clear
`ifdef RX_BREAK_DETECT_EN
    ,
    output logic                     break_det
`endif
);

    localparam logic [CFG_DBW-1:0] c_max_bits = CFG_DBW'(MAX_DATA_BITS);

    rx_state_e                r_state;
    rx_state_e                w_next;
    rx_state_e                w_after_fin;
    rx_cfg_t                  r_cfg;
    rx_cfg_t                  w_cfg_in;
    logic [DBW-1:0]           r_bit_cnt;
    logic                     r_parity_bad;
    logic                     r_stop_bad;
    logic                     r_fin;
    logic                     r_done;
    logic                     r_perr;
    logic                     r_ferr;
    logic [MAX_DATA_BITS-1:0] r_rx_data;

    logic                     w_start;
    logic                     w_shift;
    logic                     w_last_data;
    logic                     w_final;
    logic                     w_stop_bad_now;
    logic                     w_is_break;
    logic                     w_xor;
    logic [MAX_DATA_BITS-1:0] w_word;
    logic [CFG_DBW-1:0]       w_shamt;

    assign w_cfg_in.data_bits  = clamp_data_bits(CFG_DBW'(cfg_data_bits), c_max_bits);
    assign w_cfg_in.parity_en  = cfg_parity_en;
    assign w_cfg_in.parity_odd = cfg_parity_odd;
    assign w_cfg_in.stop2      = cfg_stop2;

    assign w_start        = (r_state == IDLE) && start_detect;
    assign w_shift        = (r_state == DATA) && sample_edge;
    assign w_last_data    = (CFG_DBW'(r_bit_cnt) == (r_cfg.data_bits - CFG_DBW'(1)));
    assign w_stop_bad_now = r_stop_bad | ~rx_bit;
    assign w_shamt        = c_max_bits - r_cfg.data_bits;

    // r_fin marks the completion cycle; the state is held there so a start
    // pulse coinciding with done is dropped rather than accepted.
    assign w_final = sample_edge && !r_fin &&
                     (((r_state == STOP1) && !r_cfg.stop2) || (r_state == STOP2));

`ifdef RX_BREAK_DETECT_EN
    logic r_brk;
    logic r_all_zero;

    assign w_is_break  = r_all_zero & ~rx_bit;
    assign w_after_fin = r_brk ? BRK_WAIT : IDLE;
    assign break_det   = r_brk;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_brk      <= 1'b0;
            r_all_zero <= 1'b0;
        end else begin
            r_brk <= w_final & w_is_break;
            if (w_start) begin
                r_all_zero <= 1'b1;
            end else if (sample_edge && !r_fin &&
                         (r_state inside {START, DATA, PARITY, STOP1, STOP2})) begin
                r_all_zero <= r_all_zero & ~rx_bit;
            end
        end
    end
`else
    assign w_is_break  = 1'b0;
    assign w_after_fin = IDLE;
`endif

    rx_shift_parity #(
        .MAX_DATA_BITS (MAX_DATA_BITS)
    ) u_shift (
        .clk        (pclk),
        .rst        (preset),
        .i_clear    (w_start),
        .i_shift_en (w_shift),
        .i_bit      (rx_bit),
        .o_word     (w_word),
        .o_xor      (w_xor)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_detect) w_next = START;
            end
            START: begin
                if (sample_edge) w_next = rx_bit ? IDLE : DATA;
            end
            DATA: begin
                if (sample_edge && w_last_data) w_next = r_cfg.parity_en ? PARITY : STOP1;
            end
            PARITY: begin
                if (sample_edge) w_next = STOP1;
            end
            STOP1: begin
                if (r_fin) begin
                    w_next = w_after_fin;
                end else if (sample_edge && r_cfg.stop2) begin
                    w_next = STOP2;
                end
            end
            STOP2: begin
                if (r_fin) w_next = w_after_fin;
            end
`ifdef RX_BREAK_DETECT_EN
            BRK_WAIT: begin
                if (sample_edge && rx_bit) w_next = IDLE;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != IDLE);
        sample_clear = w_start && !preset;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_cfg        <= '0;
            r_bit_cnt    <= '0;
            r_parity_bad <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_fin        <= 1'b0;
            r_done       <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_rx_data    <= '0;
        end else begin
            if (w_start) begin
                r_cfg        <= w_cfg_in;
                r_bit_cnt    <= '0;
                r_parity_bad <= 1'b0;
                r_stop_bad   <= 1'b0;
            end
            if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + DBW'(1);
            end
            if ((r_state == PARITY) && sample_edge) begin
                r_parity_bad <= ((w_xor ^ rx_bit) != r_cfg.parity_odd);
            end
            if ((r_state == STOP1) && sample_edge && !r_fin) begin
                r_stop_bad <= w_stop_bad_now;
            end
            r_fin  <= w_final;
            r_done <= w_final & ~w_is_break;
            r_perr <= w_final & ~w_is_break & r_parity_bad & r_cfg.parity_en;
            r_ferr <= w_final & ~w_is_break & w_stop_bad_now;
            if (w_final && !w_is_break) begin
                r_rx_data <= w_word >> w_shamt;
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign receive_done = r_done;
    assign parity_err   = r_perr;
    assign frame_err    = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_sequencer.sv
// ============================================================================
// Module      : tb_rx_frame_sequencer
// Description : Directed self-checking bench with a frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_frame_sequencer;

    localparam int MAXB = 8;
    localparam int DBW  = $clog2(MAXB + 1);

    logic            pclk = 1'b0;
    logic            preset;
    logic            start_detect;
    logic            sample_edge;
    logic            rx_bit;
    logic [DBW-1:0]  cfg_data_bits;
    logic            cfg_parity_en;
    logic            cfg_parity_odd;
    logic            cfg_stop2;
    logic [MAXB-1:0] rx_data;
    logic            receive_done;
    logic            parity_err;
    logic            frame_err;
    logic            busy;
    logic            sample_clear;
`ifdef RX_BREAK_DETECT_EN
    logic            break_det;
`endif

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [MAXB+1:0] sb_q[$];
    logic [MAXB+1:0] mon_exp;
    logic            prev_done = 1'b0;

    rx_frame_sequencer #(
        .MAX_DATA_BITS (MAXB)
    ) dut (
        .pclk           (pclk),
        .preset         (preset),
        .start_detect   (start_detect),
        .sample_edge    (sample_edge),
        .rx_bit         (rx_bit),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_data        (rx_data),
        .receive_done   (receive_done),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .busy           (busy),
        .sample_clear   (sample_clear)
`ifdef RX_BREAK_DETECT_EN
        ,
        .break_det      (break_det)
`endif
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one entry per receive_done pulse.
    always @(negedge pclk) begin
        if (receive_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("done_without_frame", 32'(receive_done), 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("rx_data",    32'(rx_data),    32'(mon_exp[MAXB+1:2]));
                check("parity_err", 32'(parity_err), 32'(mon_exp[1]));
                check("frame_err",  32'(frame_err),  32'(mon_exp[0]));
            end
        end else begin
            check("flags_unqualified", 32'({parity_err, frame_err}), 32'd0);
        end
        if (prev_done) check("done_one_cycle", 32'(receive_done), 32'd0);
        prev_done = (receive_done === 1'b1);
    end

    task automatic pulse(input logic b);
        @(posedge pclk); #1;
        rx_bit      = b;
        sample_edge = 1'b1;
        @(posedge pclk); #1;
        sample_edge = 1'b0;
        rx_bit      = 1'b1;
    endtask

    task automatic start_pulse();
        @(posedge pclk); #1;
        start_detect = 1'b1;
        @(posedge pclk); #1;
        start_detect = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input int db_raw, input bit pen,
                              input bit podd, input bit pbit, input bit s2,
                              input bit st1, input bit st2, input bit expect_done);
        int          n;
        int          ones;
        logic [7:0]  d;
        bit          pe;
        bit          fe;
        n    = (db_raw < 5) ? 5 : ((db_raw > MAXB) ? MAXB : db_raw);
        d    = '0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            d[i] = data[i];
            ones += int'(data[i]);
        end
        pe = pen && (((ones + int'(pbit)) % 2) != int'(podd));
        fe = !st1 || (s2 && !st2);
        cfg_data_bits  = DBW'(db_raw);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = s2;
        start_pulse();
        // Config is scrambled mid-frame; the latched copy must be used.
        cfg_data_bits  = DBW'($urandom_range(0, 15));
        cfg_parity_en  = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        cfg_stop2      = 1'($urandom);
        if (expect_done) sb_q.push_back({d, pe, fe});
        pulse(1'b0);
        for (int i = 0; i < n; i++) pulse(data[i]);
        if (pen) pulse(pbit);
        pulse(st1);
        if (s2) pulse(st2);
        if (expect_done) begin
            @(negedge pclk);
            check("done_latency", 32'(receive_done), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        preset         = 1'b1;
        start_detect   = 1'b0;
        sample_edge    = 1'b0;
        rx_bit         = 1'b1;
        cfg_data_bits  = DBW'(8);
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop2      = 1'b0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        check("reset_done",  32'(receive_done), 32'd0);
        check("reset_busy",  32'(busy),         32'd0);
        check("reset_data",  32'(rx_data),      32'd0);
        check("reset_sclr",  32'(sample_clear), 32'd0);

        // Sample strobes in IDLE do nothing.
        pulse(1'b0);
        @(negedge pclk);
        check("idle_ignores_sample", 32'(busy), 32'd0);

        // sample_clear accompanies start acceptance; then false start.
        @(posedge pclk); #1 start_detect = 1'b1;
        @(negedge pclk);
        check("sample_clear_pulse", 32'(sample_clear), 32'd1);
        @(posedge pclk); #1 start_detect = 1'b0;
        @(negedge pclk);
        check("busy_in_start",  32'(busy),         32'd1);
        check("sclr_one_cycle", 32'(sample_clear), 32'd0);
        pulse(1'b1);
        @(negedge pclk);
        check("false_start_idle", 32'(busy), 32'd0);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge pclk);
        check("idle_after_done", 32'(busy), 32'd0);

        // 7E1 0x41 with wrong then correct parity
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // 5O2 0x1F, second stop bit low
        send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        // False start followed by a good 8N1 0x3C
        start_pulse();
        pulse(1'b1);
        @(negedge pclk);
        check("false_start2_idle", 32'(busy), 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset after four data bits discards the frame
        cfg_data_bits = DBW'(8);
        cfg_parity_en = 1'b0;
        cfg_stop2     = 1'b0;
        start_pulse();
        pulse(1'b0);
        for (int i = 0; i < 4; i++) pulse(1'b1);
        @(posedge pclk); #1 preset = 1'b1;
        @(posedge pclk); #1 preset = 1'b0;
        @(negedge pclk);
        check("abort_busy", 32'(busy),    32'd0);
        check("abort_data", 32'(rx_data), 32'd0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Out-of-range data-bit counts are clamped
        send_frame(8'hB6, 2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(8'hC3, 13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Start pulse during the done cycle is dropped
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        start_detect = 1'b1;
        @(posedge pclk); #1 start_detect = 1'b0;
        @(negedge pclk);
        check("coincident_start_dropped", 32'(busy), 32'd0);

        // 8E2 0x96, all good
        send_frame(8'h96, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

`ifdef RX_BREAK_DETECT_EN
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge pclk);
        check("break_det_pulse", 32'(break_det),    32'd1);
        check("break_no_done",   32'(receive_done), 32'd0);
        @(negedge pclk);
        check("break_one_cycle", 32'(break_det), 32'd0);
        check("break_wait_busy", 32'(busy),      32'd1);
        check("break_data_held", 32'(rx_data),   32'h96);
        start_pulse();
        @(negedge pclk);
        check("break_ignores_start", 32'(busy), 32'd1);
        pulse(1'b0);
        @(negedge pclk);
        check("break_low_stays", 32'(busy), 32'd1);
        pulse(1'b1);
        @(negedge pclk);
        check("break_release", 32'(busy), 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
`else
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        repeat (5) @(negedge pclk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
